// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store path.
// Data requests have priority, and a streak limit keeps fetch from starving.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TMO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         streak_r, streak_s;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic               owner_fetch_r, owner_fetch_s;
  logic               mem_req_r, mem_req_s;
  logic               mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]  mem_wdata_r, mem_wdata_s;
  logic               if_ack_r, if_ack_s;
  logic               d_ack_r, d_ack_s;
  logic [DATA_W-1:0]  if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0]  d_rdata_r, d_rdata_s;
  logic               err_r, err_s;
  logic               busy_r, busy_s;
  logic               data_req_s;
  logic               fetch_win_s;
  logic               timed_out_s;
  logic [DATA_W-1:0]  done_rdata_s;

  assign data_req_s  = d_read | d_write;
  // Fetch only overtakes a pending data request once the streak limit is hit.
  assign fetch_win_s = if_req & (~data_req_s | (streak_r == 4'(MAX_STREAK)));
  assign timed_out_s = TMO_EN & (timer_r == TMR_W'(TMR_LAST));
  assign done_rdata_s = mem_we_r ? {DATA_W{1'b0}} : mem_rdata;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_s       = state_r;
    streak_s      = streak_r;
    timer_s       = timer_r;
    owner_fetch_s = owner_fetch_r;
    mem_req_s     = mem_req_r;
    mem_we_s      = mem_we_r;
    mem_addr_s    = mem_addr_r;
    mem_wdata_s   = mem_wdata_r;
    if_ack_s      = 1'b0;
    d_ack_s       = 1'b0;
    if_rdata_s    = if_rdata_r;
    d_rdata_s     = d_rdata_r;
    err_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fetch_win_s) begin
          state_s       = ST_BUSY;
          owner_fetch_s = 1'b1;
          mem_req_s     = 1'b1;
          mem_we_s      = 1'b0;
          mem_addr_s    = if_addr;
          streak_s      = 4'd0;
          timer_s       = {TMR_W{1'b0}};
        end else if (data_req_s) begin
          state_s       = ST_BUSY;
          owner_fetch_s = 1'b0;
          mem_req_s     = 1'b1;
          mem_we_s      = d_write;
          mem_addr_s    = d_addr;
          mem_wdata_s   = d_wdata;
          timer_s       = {TMR_W{1'b0}};
          if (if_req && (streak_r < 4'(MAX_STREAK))) begin
            streak_s = streak_r + 4'd1;
          end else if (if_req) begin
            streak_s = streak_r;
          end else begin
            streak_s = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack || timed_out_s) begin
          state_s   = ST_DONE;
          mem_req_s = 1'b0;
          err_s     = ~mem_ack;
          // A timed-out access returns zero data regardless of direction.
          if (owner_fetch_r) begin
            if_ack_s   = 1'b1;
            if_rdata_s = mem_ack ? done_rdata_s : {DATA_W{1'b0}};
          end else begin
            d_ack_s   = 1'b1;
            d_rdata_s = mem_ack ? done_rdata_s : {DATA_W{1'b0}};
          end
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        timer_s = {TMR_W{1'b0}};
      end
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
        timer_s   = {TMR_W{1'b0}};
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      streak_r      <= 4'd0;
      timer_r       <= {TMR_W{1'b0}};
      owner_fetch_r <= 1'b0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wdata_r   <= {DATA_W{1'b0}};
      if_ack_r      <= 1'b0;
      d_ack_r       <= 1'b0;
      if_rdata_r    <= {DATA_W{1'b0}};
      d_rdata_r     <= {DATA_W{1'b0}};
      err_r         <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      streak_r      <= streak_s;
      timer_r       <= timer_s;
      owner_fetch_r <= owner_fetch_s;
      mem_req_r     <= mem_req_s;
      mem_we_r      <= mem_we_s;
      mem_addr_r    <= mem_addr_s;
      mem_wdata_r   <= mem_wdata_s;
      if_ack_r      <= if_ack_s;
      d_ack_r       <= d_ack_s;
      if_rdata_r    <= if_rdata_s;
      d_rdata_r     <= d_rdata_s;
      err_r         <= err_s;
      busy_r        <= busy_s;
    end
  end

  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign err       = err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF) and the data load/store path.
- The data path is driven by the control unit's mem_read/mem_write decode.
- Arbitrates with data-first priority and a fetch anti-starvation limit, sequences each access through an FSM, and times out hung accesses.
- Sits between the core (fetch unit and LSU) and the unified instruction/data memory; the core stalls on busy or pending ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced; range 1..15.
- TIMEOUT, 255, BUSY cycles before an access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
- d_read  in  1  load request (from mem_read).
- d_write  in  1  store request (from mem_write).
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- err  out  1  qualifies if_ack/d_ack: access timed out.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset:** synchronous; when rst_n=0 at an edge, state=IDLE, streak=0, timer=0, and all outputs are 0.
  - Reset mid-access abandons the access with no ack generated.
- **Outputs:** all outputs are registered.
- **States:**
  - IDLE: evaluates requests.
  - BUSY: mem_req=1, outputs stable.
  - DONE: ack pulse; requests are ignored.
- **IDLE arbitration** (sampled each edge):
  - data_req = d_read|d_write.
  - If both data_req and if_req are high, data wins unless streak==MAX_STREAK, in which case fetch wins.
  - The winner's addr/wdata/we are latched into the mem_* registers, and the state goes to BUSY.
  - we = d_write. If d_read and d_write are both high, it is a write.
  - Fetch is always we=0.
  - With no request, the FSM stays in IDLE.
- **Streak counter:**
  - Increments on a data grant while if_req=1, saturating at MAX_STREAK.
  - Clears to 0 on a fetch grant, or on a data grant while if_req=0.
- **BUSY:**
  - mem_req=1 with mem_addr/mem_we/mem_wdata constant; the timer increments each cycle.
  - On mem_ack=1: go to DONE, mem_req=0 next cycle, capture mem_rdata into the owner's rdata (0 for writes), and assert the owner's ack with err=0.
  - On timer reaching TIMEOUT (TIMEOUT>0) without mem_ack: go to DONE, owner ack=1, err=1, rdata=0, mem_req=0.
- **DONE:**
  - Exactly one cycle with the owner's ack=1; the other ack stays 0. Then return to IDLE and clear the timer.
  - The requester must drop or replace its request at the edge ending DONE.
- **rdata hold:** if_rdata/d_rdata hold their last value when not acked.
- **Spurious mem_ack:** mem_ack in IDLE or DONE is ignored.
- **Latency:** request sampled at edge E0 → mem_req at E1 → mem_ack in the cycle after E1 → ack at E2.
  - Minimum is 3 cycles per access (IDLE, BUSY, DONE). Back-to-back accesses are spaced by the IDLE cycle.
- **Request changes during BUSY:** a request dropped or changed while BUSY does not affect the in-flight access.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100, mem_ack the cycle after mem_req with mem_rdata=0x00500093 → mem_addr=0x100, mem_we=0, if_ack one cycle with if_rdata=0x00500093, d_ack=0, err=0, busy low afterwards.
2. Store: d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF, memory acks after 3 wait cycles → mem_req high for 4 cycles with stable outputs, mem_we=1, d_ack with d_rdata=0.
3. Contention: d_read and if_req held continuously, MAX_STREAK=4, immediate mem_ack → grant order D,D,D,D,IF,D,D,D,D,IF; no grant ever issued in a DONE cycle.
4. Timeout: TIMEOUT=8, d_read=1, mem_ack never asserted → mem_req high 8 cycles, then d_ack=1 with err=1 and d_rdata=0, then IDLE.
5. Reset mid-access: rst_n=0 while BUSY → next edge all outputs 0, no ack; an if_req after release is served normally with streak=0.
6. Edge cases: d_read=d_write=1 → write issued; a spurious mem_ack in IDLE → no ack and no state change.
